// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the instruction-fetch stage.
//   NOP_INSTR     : all-zero bubble (sll $0,$0,0); downstream control decodes it to no writes
//   PC_INC        : sequential PC step
//   fetch_state_t : fetch FSM states
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// pc_counter: program-counter register with hold / load / increment.
//   clk, rst_n : clock, asynchronous active-low reset (PC -> PC_RESET)
//   i_load     : load i_load_pc (word aligned) this edge; wins over i_inc
//   i_load_pc  : load target, bits [1:0] are dropped
//   i_inc      : advance PC by PC_INC (wraps modulo 2^32)
//   o_pc       : current PC
// With neither i_load nor i_inc the PC holds.
module pc_counter
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_load_pc,
    input  logic        i_inc,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pc <= PC_RESET;
        else if (i_load)
            r_pc <= i_load_pc & ~32'h0000_0003;
        else if (i_inc)
            r_pc <= r_pc + PC_INC;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage and IF/ID pipeline register.
//   clk, rst_n         : clock, asynchronous active-low reset
//   imem_addr          : word address into the combinational instruction ROM (pc[IMEM_AW+1:2])
//   imem_rdata         : instruction at imem_addr, same cycle
//   stall              : load-use hazard, hold PC and IF/ID
//   redirect_valid/_pc : taken branch/jump from EX; flushes IF/ID and loads the PC
//   halt_ex            : syscall halt from EX; freezes fetch (HALTED)
//   resume             : leave HALTED and continue from the frozen PC
//   pc_if_id           : PC+4 of the fetched instruction
//   instruction_if_id  : fetched instruction (NOP bubble on flush/halt)
//   halted             : high while HALTED
//   fetch_count        : delivered instructions   (FETCH_PERF_CNT_EN, else 0)
//   stall_count        : stalled RUN cycles       (FETCH_PERF_CNT_EN, else 0)
// Optional feature macro: FETCH_PERF_CNT_EN enables the two performance counters.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               halt_ex,
    input  logic               resume,
    output logic [31:0]        pc_if_id,
    output logic [31:0]        instruction_if_id,
    output logic               halted,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
);

    fetch_state_t r_state;
    logic         r_halted;
    logic [31:0]  r_pc_if_id;
    logic [31:0]  r_instr_if_id;

    logic [31:0]  w_pc;
    logic [31:0]  w_pc_plus4;
    logic         w_run;
    logic         w_redirect;
    logic         w_normal;
    logic         w_stalled;

    // Priority in RUN: halt_ex > redirect_valid > stall > normal; HALTED ignores all but resume.
    assign w_run      = (r_state == RUN);
    assign w_redirect = w_run && !halt_ex && redirect_valid;
    assign w_normal   = w_run && !halt_ex && !redirect_valid && !stall;
    assign w_stalled  = w_run && !halt_ex && !redirect_valid && stall;
    assign w_pc_plus4 = w_pc + PC_INC;

    pc_counter #(
        .PC_RESET (PC_RESET)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_redirect),
        .i_load_pc (redirect_pc),
        .i_inc     (w_normal),
        .o_pc      (w_pc)
    );

    assign imem_addr = w_pc[IMEM_AW+1:2];

    // FSM and IF/ID register together so halted and the bubble change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_halted      <= 1'b0;
            r_pc_if_id    <= 32'h0;
            r_instr_if_id <= NOP_INSTR;
        end else begin
            case (r_state)
                RUN: begin
                    if (halt_ex) begin
                        r_state       <= HALTED;
                        r_halted      <= 1'b1;
                        r_pc_if_id    <= 32'h0;
                        r_instr_if_id <= NOP_INSTR;
                    end else if (redirect_valid) begin
                        r_pc_if_id    <= 32'h0;
                        r_instr_if_id <= NOP_INSTR;
                    end else if (!stall) begin
                        r_pc_if_id    <= w_pc_plus4;
                        r_instr_if_id <= imem_rdata;
                    end
                end
                HALTED: begin
                    r_pc_if_id    <= 32'h0;
                    r_instr_if_id <= NOP_INSTR;
                    // A fresh halt in the same cycle as resume keeps us halted.
                    if (resume && !halt_ex) begin
                        r_state  <= RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign pc_if_id          = r_pc_if_id;
    assign instruction_if_id = r_instr_if_id;
    assign halted            = r_halted;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= 32'h0;
            r_stall_count <= 32'h0;
        end else begin
            if (w_normal)  r_fetch_count <= r_fetch_count + 32'd1;
            if (w_stalled) r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`else
    logic w_unused_stalled;
    assign w_unused_stalled = w_stalled;
    assign fetch_count      = 32'h0;
    assign stall_count      = 32'h0;
`endif

endmodule
